stream_prefetch_buffer: RTL and testbench

STREAM_PREFETCH_BUFFER -- requirements
Module: stream_prefetch_buffer

---
 rtl/prefetch_pkg.sv | 19 +
 rtl/prefetch_line_buf.sv | 66 ++++++
 rtl/stream_prefetch_buffer.sv | 168 ++++++++++++++++
 tb/tb_stream_prefetch_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared FSM state type and line-geometry helpers for the stream prefetch buffer.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2,
    WRITE    = 2'd3
  } pf_state_e;

  function automatic int line_bytes(input int line_w);
    return line_w / 8;
  endfunction

  function automatic int line_off_w(input int line_w);
    return $clog2(line_bytes(line_w));
  endfunction

endpackage

// File: rtl/prefetch_line_buf.sv
// Prefetch entry array: tag lookup, candidate probe, tag invalidate and FIFO install.
module prefetch_line_buf
  import prefetch_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int TAG_W  = 27,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  input  logic [TAG_W-1:0]  probe_tag,
  output logic              probe_hit,
  input  logic              inv_en,
  input  logic [TAG_W-1:0]  inv_tag,
  input  logic              inst_en,
  input  logic [TAG_W-1:0]  inst_tag,
  input  logic [LINE_W-1:0] inst_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];

  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    probe_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_tag) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[i];
      end
      if (valid_q[i] && tag_q[i] == probe_tag) probe_hit = 1'b1;
    end
  end

  // Replacement is strictly FIFO: the pointer overwrites its slot whether or not it is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && valid_q[i] && tag_q[i] == inv_tag) valid_q[i] <= 1'b0;
      end
      if (inst_en) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inst_en) begin
      tag_q[wr_ptr_q]  <= inst_tag;
      data_q[wr_ptr_q] <= inst_data;
    end
  end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Next-line stream prefetch buffer between L2 and memory; define PREFETCH_STATS_EN
// to add saturating hit/miss/issue counters.
module stream_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int DEGREE    = 2,
  parameter int PAGE_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
`ifdef PREFETCH_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       issue_cnt,
`endif
  output logic [1:0]        state_dbg
);

  localparam int OFF_W = line_off_w(LINE_W);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PG_W  = ADDR_W - PAGE_BITS;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pf_state_e        state_q;
  logic [TAG_W-1:0] cur_tag_q, cand_tag_q, req_tag;
  logic [PG_W-1:0]  page_q;
  logic [CNT_W-1:0] cand_left_q;
  logic             busy_q, pmem_read_q, pmem_write_q;
  logic             lookup_hit, probe_hit, off_page, l2_req;
  logic             hit_now, miss_now, cand_turn, skip_now, issue_now, inst_en;
  logic [LINE_W-1:0] lookup_data;
  logic             unused_addr_bits;

  assign req_tag          = l2_addr[ADDR_W-1:OFF_W];
  assign unused_addr_bits = ^l2_addr[OFF_W-1:0];
  assign l2_req           = l2_read | l2_write;
  assign off_page         = cand_tag_q[TAG_W-1 -: PG_W] != page_q;

  // A write wins over a simultaneous read, so a read only counts when l2_write is low.
  assign hit_now   = state_q == IDLE && l2_read && !l2_write && lookup_hit;
  assign miss_now  = state_q == IDLE && l2_read && !l2_write && !lookup_hit;
  assign cand_turn = state_q == PREFETCH && !busy_q && !l2_req && cand_left_q != '0;
  assign skip_now  = cand_turn && (probe_hit || off_page);
  assign issue_now = cand_turn && !skip_now;
  assign inst_en   = state_q == PREFETCH && busy_q && pmem_resp;

  assign l2_resp    = hit_now || ((state_q == DEMAND || state_q == WRITE) && pmem_resp);
  assign l2_rdata   = (state_q == DEMAND) ? pmem_rdata : lookup_data;
  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign pmem_addr  = {(state_q == PREFETCH) ? cand_tag_q : cur_tag_q, {OFF_W{1'b0}}};
  assign pmem_wdata = l2_wdata;
  assign state_dbg  = state_q;

  prefetch_line_buf #(.LINE_W(LINE_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_tag  (req_tag),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .probe_tag   (cand_tag_q),
    .probe_hit   (probe_hit),
    .inv_en      (state_q == IDLE && l2_write),
    .inv_tag     (req_tag),
    .inst_en     (inst_en),
    .inst_tag    (cand_tag_q),
    .inst_data   (pmem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_tag_q    <= '0;
      cand_tag_q   <= '0;
      page_q       <= '0;
      cand_left_q  <= '0;
      busy_q       <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (l2_write) begin
            state_q      <= WRITE;
            cur_tag_q    <= req_tag;
            pmem_write_q <= 1'b1;
          end else if (hit_now) begin
            state_q     <= PREFETCH;
            cand_tag_q  <= req_tag + TAG_W'(1);
            page_q      <= req_tag[TAG_W-1 -: PG_W];
            cand_left_q <= CNT_W'(DEGREE);
          end else if (miss_now) begin
            state_q     <= DEMAND;
            cur_tag_q   <= req_tag;
            pmem_read_q <= 1'b1;
          end
        end
        DEMAND: begin
          if (pmem_resp) begin
            state_q     <= PREFETCH;
            pmem_read_q <= 1'b0;
            cand_tag_q  <= cur_tag_q + TAG_W'(1);
            page_q      <= cur_tag_q[TAG_W-1 -: PG_W];
            cand_left_q <= CNT_W'(DEGREE);
          end
        end
        PREFETCH: begin
          if (busy_q) begin
            // An L2 request seen at completion drops the remaining candidates.
            if (pmem_resp) begin
              busy_q      <= 1'b0;
              pmem_read_q <= 1'b0;
              cand_tag_q  <= cand_tag_q + TAG_W'(1);
              cand_left_q <= l2_req ? '0 : cand_left_q - CNT_W'(1);
              if (l2_req) state_q <= IDLE;
            end
          end else if (skip_now) begin
            cand_tag_q  <= cand_tag_q + TAG_W'(1);
            cand_left_q <= cand_left_q - CNT_W'(1);
          end else if (issue_now) begin
            busy_q      <= 1'b1;
            pmem_read_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            cand_left_q <= '0;
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_write_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      issue_cnt <= '0;
    end else begin
      if (hit_now && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (miss_now && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (issue_now && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed bench for stream_prefetch_buffer with a slot-level buffer model and a memory responder.
module tb_stream_prefetch_buffer;

  localparam int LINE_W = 256, ADDR_W = 32, DEPTH = 4, DEGREE = 2, PAGE_BITS = 12;
  localparam int LB = LINE_W / 8, MEM_LAT = 3;

  logic              clk = 1'b0, rst;
  logic              l2_read, l2_write, l2_resp, pmem_read, pmem_write, pmem_resp;
  logic [ADDR_W-1:0] l2_addr, pmem_addr;
  logic [LINE_W-1:0] l2_wdata, l2_rdata, pmem_wdata, pmem_rdata;
  logic [1:0]        state_dbg;
`ifdef PREFETCH_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt, issue_cnt;
`endif

  stream_prefetch_buffer #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                           .DEGREE(DEGREE), .PAGE_BITS(PAGE_BITS)) dut (
    .clk(clk), .rst(rst), .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
`ifdef PREFETCH_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .issue_cnt(issue_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0, n_err = 0, mem_cnt = 0;
  logic [ADDR_W:0] exp_q[$];   // {is_write, line address} expected on pmem, in order

  logic [ADDR_W-1:0] m_addr [DEPTH];
  bit                m_v    [DEPTH];
  int                m_ptr;

  task automatic check(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'h0101_0101 * i);
    return v;
  endfunction

  function automatic bit m_lookup(input logic [ADDR_W-1:0] la);
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_addr[i] == la) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endtask

  // Candidates are the DEGREE lines after base, same page only, not already buffered.
  task automatic m_prefetch(input logic [ADDR_W-1:0] base, input bit interrupted);
    logic [ADDR_W-1:0] c;
    for (int k = 1; k <= DEGREE; k++) begin
      c = base + ADDR_W'(k * LB);
      if (c[ADDR_W-1:PAGE_BITS] != base[ADDR_W-1:PAGE_BITS] || m_lookup(c)) continue;
      exp_q.push_back({1'b0, c});
      m_addr[m_ptr] = c;
      m_v[m_ptr]    = 1'b1;
      m_ptr         = (m_ptr + 1) % DEPTH;
      if (interrupted) break;
    end
  endtask

  // ---------------- memory responder (pmem compare) ----------------
  initial begin
    logic [ADDR_W:0] e;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (pmem_read || pmem_write)) begin
        mem_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pmem_unexpected: got wr=%0b addr %h, none expected", pmem_write, pmem_addr);
        end else begin
          e = exp_q.pop_front();
          check("pmem_access", {pmem_write, pmem_addr}, e);
        end
        if (pmem_write) check("pmem_wdata", pmem_wdata, l2_wdata);
        repeat (MEM_LAT - 1) @(negedge clk);
        @(posedge clk); #1;
        pmem_resp  = 1'b1;
        pmem_rdata = pmem_write ? '0 : mem_line(pmem_addr);
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
      end
    end
  end

  // ---------------- per-cycle protocol monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (pmem_read && pmem_write) begin
        n_err++;
        $display("FAIL pmem_excl: read=%0b write=%0b required not both", pmem_read, pmem_write);
      end
      if (l2_resp && !(l2_read || l2_write)) begin
        n_err++;
        $display("FAIL l2_resp_idle: l2_resp=1 with no l2 request, required 0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic l2_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] exp_data, input int exp_lat, input bit chk_data);
    int lat = 0;
    bit got = 0;
    l2_read  = rd;
    l2_write = wr;
    l2_addr  = a;
    l2_wdata = {8{$urandom()}};
    while (!got && lat < 300) begin
      @(negedge clk);
      if (l2_resp) begin
        got = 1;
        if (chk_data) check("l2_rdata", l2_rdata, exp_data);
        if (exp_lat >= 0) check("l2_latency", LINE_W'(lat), LINE_W'(exp_lat));
      end else lat++;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL l2_timeout: no l2_resp for addr %h, required one", a);
    end
    @(posedge clk); #1;
    l2_read  = 1'b0;
    l2_write = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input bit interrupt);
    logic [ADDR_W-1:0] la;
    bit hit;
    la  = {a[ADDR_W-1:5], 5'b0};
    hit = m_lookup(la);
    if (!hit) exp_q.push_back({1'b0, la});
    m_prefetch(la, interrupt);
    l2_op(1'b1, 1'b0, a, mem_line(la), hit ? 0 : -1, 1'b1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input bit with_read);
    logic [ADDR_W-1:0] la;
    la = {a[ADDR_W-1:5], 5'b0};
    exp_q.push_back({1'b1, la});
    for (int i = 0; i < DEPTH; i++) if (m_addr[i] == la) m_v[i] = 1'b0;
    l2_op(with_read, 1'b1, a, '0, -1, 1'b0);
  endtask

  task automatic quiesce();
    int quiet = 0, t = 0;
    while (quiet < 6 && t < 400) begin
      @(negedge clk);
      t++;
      if (exp_q.size() == 0 && !pmem_read && !pmem_write && !pmem_resp) quiet++;
      else quiet = 0;
    end
    if (quiet < 6) begin
      n_vec++; n_err++;
      $display("FAIL quiesce: %0d expected pmem accesses still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic read_op(input string name, input logic [ADDR_W-1:0] a, input int exp_accesses);
    int c0 = mem_cnt;
    do_read(a, 1'b0);
    quiesce();
    check(name, LINE_W'(mem_cnt - c0), LINE_W'(exp_accesses));
  endtask

  task automatic wait_exp_drained(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: %0d accesses not issued, required 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst_l2_resp", LINE_W'(l2_resp), '0);
    check("rst_pmem_read", LINE_W'(pmem_read), '0);
    check("rst_pmem_write", LINE_W'(pmem_write), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    l2_read = 1'b0; l2_write = 1'b0; l2_addr = '0; l2_wdata = '0;
    m_reset();
    do_reset(3);

    read_op("cnt_miss_1000", 32'h0000_1000, 3);   // demand 1000, prefetch 1020, 1040
    read_op("cnt_hit_1020", 32'h0000_1020, 1);    // hit; 1040 buffered, prefetch 1060
    read_op("cnt_page_1fe0", 32'h0000_1FE0, 1);   // 2000/2020 cross the page
    c0 = mem_cnt;
    do_write(32'h0000_1044, 1'b1);                // read+write together acts as write
    quiesce();
    check("cnt_write_1040", LINE_W'(mem_cnt - c0), LINE_W'(1));
    read_op("cnt_miss_1040", 32'h0000_1040, 2);   // invalidated: demand 1040, prefetch 1080

    c0 = mem_cnt;
    do_read(32'h0000_3000, 1'b1);                 // 3020 fetched, 3040 dropped
    wait_exp_drained("interrupt_issue");
    do_read(32'h0000_5000, 1'b0);
    quiesce();
    check("cnt_interrupt", LINE_W'(mem_cnt - c0), LINE_W'(5));

    read_op("cnt_miss_7000", 32'h0000_7000, 3);
    read_op("cnt_miss_8000", 32'h0000_8000, 3);
    read_op("cnt_miss_9000", 32'h0000_9000, 3);
    read_op("cnt_evicted_7020", 32'h0000_7020, 3); // 7020 evicted by FIFO replacement
    read_op("cnt_hit_9020", 32'h0000_9020, 1);

    read_op("cnt_wrap_top", 32'hFFFF_FFE0, 1);     // wrapped candidate 0x0 is off-page
    read_op("cnt_miss_zero", 32'h0000_0000, 3);
    read_op("cnt_hit_0020", 32'h0000_0020, 1);

    c0 = mem_cnt;
    l2_addr = 32'h0000_A000;
    exp_q.push_back({1'b0, 32'h0000_A000});
    l2_read = 1'b1;
    wait_exp_drained("midreset_issue");
    l2_read = 1'b0;
    do_reset(MEM_LAT + 3);                         // abandon the demand read
    check("cnt_midreset", LINE_W'(mem_cnt - c0), LINE_W'(1));
    read_op("cnt_after_reset_0", 32'h0000_0000, 3);

    check("exp_q_drained", LINE_W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
